// File: rtl/axi2uart_pkg.sv
// Shared definitions for the axi2uart IP: transmit FSM states and frame constants.
package axi2uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MIN_DIV   = 3;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/axi2uart_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit, status flags are registered.
module axi2uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [CW-1:0]    count_n;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_comb begin
        count_n = count;
        if (do_wr && !do_rd) begin
            count_n = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_n = count - CW'(1);
        end
    end

    // Storage array is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_wr) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rptr <= rptr + (AW+1)'(1);
            end
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/axi2uart_tx.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser with a latched baud divisor.
module axi2uart_tx
    import axi2uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    tx_state_e              state;
    tx_state_e              state_n;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [DIV_WIDTH-1:0]   cnt_n;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_q_n;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   shift_n;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BIT_IDX_W-1:0]   bit_idx_n;
    logic [7:0]             head;
    logic                   pop;
    logic                   tx_n;

    axi2uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign div_eff = (baud_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : baud_div;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div_q   <= DIV_WIDTH'(MIN_DIV);
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_q_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
            busy    <= (state_n != ST_IDLE);
        end
    end

    // Next state, baud countdown and shifter; a pop also relatches the divisor.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_q_n   = div_q;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    div_q_n = div_eff;
                    cnt_n   = div_eff;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    cnt_n     = div_q;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    cnt_n   = div_q;
                    shift_n = shift >> 1;
                    if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        div_q_n = div_eff;
                        cnt_n   = div_eff;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, so tx leaves a flop.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    // Sticky drop flag; a dropped write outranks a clear in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi2uart_tx.sv
// Scoreboard bench for axi2uart_tx: directed test-plan scenarios plus randomized traffic.
module tb_axi2uart_tx;

    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] baud_div = 16'd9;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        ovf_clr = 1'b0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        overflow;

    axi2uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .baud_div   (baud_div),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff(input logic [15:0] v);
        return (v < 16'd3) ? 3 : int'(v);
    endfunction

    typedef struct {
        logic [7:0] data;
        int         wr;
    } exp_t;

    // Reference model state: bytes accepted but not yet started on the line.
    exp_t        sb[$];
    bit          in_frame = 1'b0;
    int          fstart;
    int          fper;
    int          prev_end = 0;
    logic [7:0]  fdata;
    logic [7:0]  dec;
    int          fbad;
    int          idle_bad = 0;
    int          stat_bad = 0;
    int          ovf_bad = 0;
    bit          ovf_exp = 1'b0;
    logic        rst_prev = 1'b1;
    logic [15:0] div_prev = 16'd9;

    // Monitor: frames start when the line drops; each one is matched to the queue head.
    always @(negedge ACLK) begin
        int c;
        int cnt;
        int o;
        int k;
        int exp_start;
        logic exp_tx;
        exp_t e;
        c = cyc;
        if (rst_prev) begin
            sb.delete();
            in_frame = 1'b0;
            prev_end = 0;
            ovf_exp  = 1'b0;
        end
        if (!in_frame && tx === 1'b0) begin
            check("frame_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                exp_start = (e.wr + 2 > prev_end) ? e.wr + 2 : prev_end;
                check("frame_start_cycle", 32'(c), 32'(exp_start));
                check("idle_line", 32'(idle_bad), 32'd0);
                idle_bad = 0;
                fstart   = c;
                fper     = eff(div_prev) + 1;
                fdata    = e.data;
                dec      = 8'h00;
                fbad     = 0;
                in_frame = 1'b1;
            end
        end
        if (in_frame) begin
            o = c - fstart;
            k = o / fper;
            if (k == 0) exp_tx = 1'b0;
            else if (k == 9) exp_tx = 1'b1;
            else exp_tx = fdata[k-1];
            if (tx !== exp_tx || busy !== 1'b1) fbad++;
            if (k >= 1 && k <= 8 && (o % fper) == fper / 2) dec[k-1] = tx;
            if (o == 10 * fper - 1) begin
                check("frame_waveform", 32'(fbad), 32'd0);
                check("frame_byte", 32'(dec), 32'(fdata));
                in_frame = 1'b0;
                prev_end = c + 1;
            end
        end else if (tx !== 1'b1 || busy !== 1'b0) begin
            idle_bad++;
        end
        cnt = 0;
        foreach (sb[i]) if (sb[i].wr < c) cnt++;
        if (fifo_count !== 5'(cnt) || fifo_full !== (cnt == DEPTH) || fifo_empty !== (cnt == 0))
            stat_bad++;
        if (overflow !== ovf_exp) ovf_bad++;
        if (!ARESET) begin
            if (wr_en && cnt == DEPTH) ovf_exp = 1'b1;
            else if (ovf_clr) ovf_exp = 1'b0;
            if (wr_en && cnt < DEPTH) sb.push_back('{wr_data, c});
        end
        rst_prev = ARESET;
        div_prev = baud_div;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic phase_end(input string name);
        check({name, "_status"}, 32'(stat_bad), 32'd0);
        check({name, "_overflow"}, 32'(ovf_bad), 32'd0);
        check({name, "_idle"}, 32'(idle_bad), 32'd0);
        stat_bad = 0;
        ovf_bad  = 0;
        idle_bad = 0;
    endtask

    initial begin
        int n;
        int s;
        int peak;

        // Reset held for three cycles.
        repeat (3) tick();
        ARESET = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single byte, 10-cycle bits.
        baud_div = 16'd9;
        tick();
        n = cyc;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("single_count_n1", 32'(fifo_count), 32'd1);
        check("single_empty_n1", 32'(fifo_empty), 32'd0);
        tick();
        check("single_tx_n2", 32'(tx), 32'd0);
        check("single_busy_n2", 32'(busy), 32'd1);
        check("single_count_n2", 32'(fifo_count), 32'd0);
        wait_to(n + 101);
        check("single_busy_n101", 32'(busy), 32'd1);
        tick();
        check("single_busy_n102", 32'(busy), 32'd0);
        check("single_tx_n102", 32'(tx), 32'd1);
        phase_end("single");

        // Three back-to-back frames at 4-cycle bits.
        baud_div = 16'd3;
        tick();
        n = cyc;
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        wr_en = 1'b0;
        while (cyc < n + 121) begin
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("b2b_peak_count", 32'(peak), 32'd2);
        check("b2b_busy_last", 32'(busy), 32'd1);
        tick();
        check("b2b_busy_end", 32'(busy), 32'd0);
        phase_end("b2b");

        // Overflow with a slow line, then flush by reset.
        baud_div = 16'd1000;
        tick();
        n = cyc;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_still_full", 32'(fifo_full), 32'd1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("ovf_rst_count", 32'(fifo_count), 32'd0);
        check("ovf_rst_empty", 32'(fifo_empty), 32'd1);
        check("ovf_rst_busy", 32'(busy), 32'd0);
        phase_end("ovf");

        // Clamped divisor, changed mid-frame.
        baud_div = 16'd1;
        tick();
        n = cyc;
        s = n + 2;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        wait_to(n + 5);
        baud_div = 16'd7;
        wait_to(s + 39);
        check("div_stop_tail", 32'(tx), 32'd1);
        tick();
        check("div_second_start", 32'(tx), 32'd0);
        wait_to(s + 119);
        check("div_busy_last", 32'(busy), 32'd1);
        tick();
        check("div_busy_end", 32'(busy), 32'd0);
        phase_end("div");

        // Reset during DATA with three bytes still queued.
        baud_div = 16'd9;
        tick();
        n = cyc;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        wait_to(n + 20);
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_count_before", 32'(fifo_count), 32'd3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        repeat (300) tick();
        check("midrst_quiet_busy", 32'(busy), 32'd0);
        phase_end("midrst");

        // Randomized traffic with divisor churn, clears and one overflowing burst.
        for (int i = 0; i < 3000; i++) begin
            wr_en   = (i >= 1500 && i < 1520) || ($urandom_range(0, 39) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) baud_div = 16'($urandom_range(0, 6));
            tick();
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        for (int i = 0; i < 5000 && (sb.size() != 0 || in_frame); i++) tick();
        check("rand_drained", 32'(sb.size()) + 32'(in_frame), 32'd0);
        phase_end("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
